// File: rtl/multi_button_debounce.sv
// -----------------------------------------------------------------------------
// multi_button_debounce
//
// N-channel push-button / switch conditioner. Each channel has its own
// 2-FF synchroniser, debounce counter, debounced level, one-cycle rise/fall
// pulses and long-press detection. All channels share one clock domain and
// are fully independent of each other.
//
// Optional feature (compile-time macro DEBOUNCE_AUTOREPEAT_EN):
//   defined   - after the first long_o pulse, long_o repeats every
//               REPEAT_CYCLES cycles for as long as the button stays pressed.
//   undefined - long_o fires at most once per press. No repeat logic is built.
//
// Ports:
//   clk          in   1     system clock, rising edge
//   rst_n        in   1     asynchronous active-low reset
//   btn_i        in   N_CH  raw asynchronous button levels
//   btn_o        out  N_CH  debounced stable level
//   rise_o       out  N_CH  one-cycle pulse on a debounced 0->1 transition
//   fall_o       out  N_CH  one-cycle pulse on a debounced 1->0 transition
//   long_o       out  N_CH  one-cycle pulse when a press lasts LONG_CYCLES
//                           (plus repeat pulses with auto-repeat enabled)
//   any_press_o  out  1     OR of all rise_o bits
// -----------------------------------------------------------------------------
module multi_button_debounce #(
  parameter int   N_CH          = 5,
  parameter int   DEB_CYCLES    = 1000000,
  parameter int   LONG_CYCLES   = 50000000,
  parameter int   REPEAT_CYCLES = 10000000,
  parameter int   CNT_W         = 21,
  parameter int   HOLD_W        = 27,
  parameter logic RST_LEVEL     = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] btn_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] long_o,
  output logic            any_press_o
);

  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`else
  localparam logic [HOLD_W-1:0] LONG_MAX  = HOLD_W'(LONG_CYCLES);
`endif

  // Parameter sanity marker: an illegal configuration elaborates this
  // (otherwise empty) block, which makes it easy to spot in a hierarchy dump.
  localparam bit PARAMS_OK = (DEB_CYCLES >= 2) && (LONG_CYCLES > 0) &&
                             (REPEAT_CYCLES > 0);
  if (!PARAMS_OK) begin : g_invalid_params
  end

  logic [N_CH-1:0] rise_vec;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic              sync0_q, sync1_q;
    logic              level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              long_q, long_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    logic              rep_q, rep_d;   // 1 once the first long pulse has fired
`endif

    // Debounce: accept the synchronised level on its DEB_CYCLES-th
    // consecutive cycle of disagreement; any agreement restarts the count.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (sync1_q != level_q) begin
        if (cnt_q == DEB_LAST) begin
          level_d = sync1_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      rise_d = level_d & ~level_q;
      fall_d = ~level_d & level_q;
    end

    // Hold counter runs on the next-state level so that a release in the
    // same cycle the target would be reached suppresses long_o.
`ifdef DEBOUNCE_AUTOREPEAT_EN
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      rep_d  = rep_q;
      if (!level_d || rise_d) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end else if (hold_q == (rep_q ? REP_LAST : LONG_LAST)) begin
        // Target reached: pulse and reload for the next repeat period.
        hold_d = '0;
        long_d = 1'b1;
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
`else
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!level_d || rise_d) begin
        hold_d = '0;
      end else if (hold_q != LONG_MAX) begin
        // Saturates at LONG_CYCLES so long_o fires once per press.
        hold_d = hold_q + 1'b1;
        long_d = (hold_q == LONG_LAST);
      end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync0_q <= RST_LEVEL;
        sync1_q <= RST_LEVEL;
        level_q <= RST_LEVEL;
        cnt_q   <= '0;
        hold_q  <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        long_q  <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rep_q   <= 1'b0;
`endif
      end else begin
        sync0_q <= btn_i[gi];
        sync1_q <= sync0_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        long_q  <= long_d;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        rep_q   <= rep_d;
`endif
      end
    end

    assign btn_o[gi]    = level_q;
    assign rise_vec[gi] = rise_q;
    assign fall_o[gi]   = fall_q;
    assign long_o[gi]   = long_q;
  end

  assign rise_o      = rise_vec;
  assign any_press_o = |rise_vec;

endmodule

// File: doc/multi_button_debounce.md
Name: multi_button_debounce

Overview:
- Parametrised N-channel successor to the single-button debouncer for board push-buttons and switches feeding the CPU I/O path.
- Per channel: 2-FF synchroniser, debounce counter, stable level, one-cycle press/release pulses, long-press detection.
- Optional auto-repeat for held buttons, e.g. single-step and scroll controls.
- Channels are fully independent; one shared clock domain.

Parameters:
- N_CH, 5, number of independent button channels.
- DEB_CYCLES, 1000000, consecutive cycles a new level must persist before acceptance (10 ms at 100 MHz); must be >= 2.
- LONG_CYCLES, 50000000, cycles of stable-pressed level before long_o fires; must be > 0.
- REPEAT_CYCLES, 10000000, auto-repeat period after a long press; used only with the optional feature; must be > 0.
- CNT_W, 21, debounce counter width; must hold DEB_CYCLES-1.
- HOLD_W, 27, hold counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES).
- RST_LEVEL, 1'b0, reset value of the stable level and both synchroniser stages, applied to all channels.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_i  input  N_CH  raw asynchronous button levels.
- btn_o  output  N_CH  debounced stable level.
- rise_o  output  N_CH  one-cycle pulse on a debounced 0->1 transition.
- fall_o  output  N_CH  one-cycle pulse on a debounced 1->0 transition.
- long_o  output  N_CH  one-cycle pulse when the press has lasted LONG_CYCLES (plus repeat pulses with the option enabled).
- any_press_o  output  1  OR-reduction of rise_o.

Behaviour:
- Reset, rst_n low, asynchronous: sync stages = RST_LEVEL, btn_o = RST_LEVEL, rise_o/fall_o/long_o/any_press_o = 0, all counters = 0.
- Release of reset is synchronous to clk. No pulses are generated by reset itself.
- Synchroniser: sync1 <= sync0 <= btn_i[k]. btn_i is never used directly.
- Debounce, per channel:
  - If sync1 == btn_o: cnt <= 0.
  - Otherwise, if cnt == DEB_CYCLES-1: btn_o <= sync1 and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Net effect: btn_o changes on the DEB_CYCLES-th consecutive cycle that sync1 differs from it.
  - Any single-cycle agreement (a glitch) restarts the count.
- Latency: a clean input step sampled at edge E appears on btn_o at edge E+1+DEB_CYCLES.
- Edge pulses:
  - rise_o[k]/fall_o[k] are registered and asserted in the same cycle btn_o[k] changes, for exactly one cycle.
  - The minimum spacing between edges on one channel is DEB_CYCLES.
- Long press, per channel:
  - Hold counter is cleared whenever btn_o == 0 and in the cycle rise_o fires.
  - While btn_o == 1 it increments and saturates at LONG_CYCLES.
  - long_o pulses once, in the cycle the counter reaches LONG_CYCLES, which is LONG_CYCLES cycles after rise_o.
  - A release before that point produces no long_o.
  - A release in the same cycle the count would be reached also produces no long_o; release wins.
- Simultaneous events: channels are independent. Multiple rise_o bits may be set together, and any_press_o is their OR in the same cycle.
- Reset mid-debounce or mid-hold discards all progress; no pulse is emitted after reset is released.
- Counter widths are unsigned, with no wrap: the debounce counter is bounded by DEB_CYCLES-1 and the hold counter saturates.

Optional Feature:
- Macro DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - After the first long_o, the hold counter reloads to 0 and counts to REPEAT_CYCLES.
  - Each time it reaches REPEAT_CYCLES, long_o pulses again and the counter reloads.
  - Repeat continues until btn_o falls; fall_o and the hold-counter clear happen in the same cycle, with no further long_o.
- Undefined: long_o fires at most once per press, and the REPEAT_CYCLES logic is not synthesised.

Test Plan:
- Bench parameters: DEB_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=8, N_CH=3.
- Reset: assert rst_n=0 mid-simulation with btn_i=3'b111 -> all outputs 0 immediately, without waiting for a clock edge. After release with btn_i held, rise_o pulses 5 cycles later and no output glitches before that.
- Clean press: btn_i[0] 0->1 at edge E -> btn_o[0]=1 and rise_o[0]=1 at E+5, for one cycle only; any_press_o=1 in the same cycle.
- Bounce: btn_i[1] toggles 1,0,1,0 every cycle, then holds 1 -> btn_o[1] rises 5 edges after the final 0->1 step; exactly one rise_o pulse.
- Long press: hold btn_i[2]=1 for 30 cycles after rise_o -> long_o[2] pulses once, 16 cycles after rise_o. With DEBOUNCE_AUTOREPEAT_EN, additional pulses at +24; release before +32 -> fall_o only, no further long_o.
- Short press: press for 10 debounced cycles, then release -> rise_o, then fall_o, with no long_o.
- Simultaneous: channels 0 and 2 stepped together -> rise_o=3'b101 in one cycle and any_press_o=1.
